pipelined_add_sub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake on both sides. The N-bit operation is split into STAGES equal carry-chained slices, one slice per pipeline stage, so wide datapaths close timing at the cost of STAGES cycles of latency. It is the clocked, wide-datapath successor to the combinational `n`-bit add/sub. It sits between operand-producing logic and result consumers, and adds back-pressure, a corrected signed-overflow flag, a zero flag and optional saturation.

---
 rtl/pipelined_add_sub_if.sv | 49 ++++
 rtl/pipelined_add_sub.sv | 176 +++++++++++++++++
 tb/tb_pipelined_add_sub.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_add_sub_if.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub_if
//
// Operand/result handshake bundle for pipelined_add_sub.
//
// Parameters:
//   N          operand/result width in bits
//
// Signals:
//   x, y       operands (two's complement)
//   s          0 = x + y, 1 = x - y
//   in_valid   operands valid this cycle
//   in_ready   adder accepts the operation this cycle
//   f          result
//   cout       carry out of bit N-1 (subtraction: 1 = no borrow)
//   ov         signed overflow
//   zero       f == 0
//   out_valid  result fields valid
//   out_ready  consumer accepts the result
//
// Modports:
//   master     operand producer / result consumer side
//   slave      the adder itself
// ---------------------------------------------------------------------------
interface pipelined_add_sub_if #(
    parameter int N = 16
);
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         s;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] f;
    logic         cout;
    logic         ov;
    logic         zero;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output x, y, s, in_valid, out_ready,
        input  in_ready, f, cout, ov, zero, out_valid
    );

    modport slave (
        input  x, y, s, in_valid, out_ready,
        output in_ready, f, cout, ov, zero, out_valid
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// pipelined_add_sub
//
// Pipelined two's-complement adder/subtractor. The N-bit operation is cut
// into STAGES carry-chained slices of W = N/STAGES bits; each pipeline stage
// adds one slice, so the widest combinational add is W+1 bits. The whole
// pipeline advances together whenever the output register is empty or being
// drained (adv = !out_valid || out_ready); otherwise every stage holds.
//
// Parameters:
//   N          operand/result width, multiple of STAGES
//   STAGES     pipeline depth / number of slices, 1..N
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        pipelined_add_sub_if.slave (x, y, s, in_valid, in_ready,
//              f, cout, ov, zero, out_valid, out_ready)
//
// Build option:
//   ADD_SUB_SATURATE_EN  when defined, an overflowing result is clamped to
//                        the most positive / most negative value in the
//                        output stage; ov and cout still report the raw
//                        condition. When undefined, f wraps around.
// ---------------------------------------------------------------------------
module pipelined_add_sub #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic                clk,
    input  logic                rst,
    pipelined_add_sub_if.slave  bus
);
    localparam int W = N / STAGES;

    // One in-flight operation. Operand slices are shifted right as they are
    // consumed, so the next slice to add is always in bits [W-1:0]. Result
    // slices enter at the top of sum and shift down, so after the last stage
    // slice 0 sits in bits [W-1:0].
    typedef struct packed {
        logic         valid;
        logic         carry;
        logic [N-1:0] sum;
        logic [N-1:0] xa;
        logic [N-1:0] yb;
    } stage_t;

    // W+1-bit add of the current slice plus the incoming carry.
    function automatic logic [W:0] slice_sum(input stage_t src);
        slice_sum = {1'b0, src.xa[W-1:0]} + {1'b0, src.yb[W-1:0]}
                  + (W+1)'(src.carry);
    endfunction

    // Consume one slice and produce the state handed to the next stage.
    function automatic stage_t advance(input stage_t src);
        logic [W:0] part;
        part          = slice_sum(src);
        advance.valid = src.valid;
        advance.carry = part[W];
        advance.sum   = (src.sum >> W) | (N'(part[W-1:0]) << (N - W));
        advance.xa    = src.xa >> W;
        advance.yb    = src.yb >> W;
    endfunction

    logic         adv;
    stage_t       head;

    // Feed of the final slice adder (taken from the last internal register,
    // or straight from the ports when there is only one stage).
    logic         last_valid;
    logic [W:0]   last_part;
    logic [N-1:0] last_low;
    logic         last_xs;
    logic         last_ys;

    logic [N-1:0] f_raw;
    logic         ov_raw;
    logic [N-1:0] f_fin;

    logic         out_valid_q;
    logic [N-1:0] f_q;
    logic         cout_q;
    logic         ov_q;
    logic         zero_q;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv;

    // An idle input cycle is simply a stage-0 operation with valid = 0,
    // which is how bubbles enter the pipeline.
    // NOTE: every field is assigned on every pass so no latch is inferred.
    always_comb begin
        head       = '0;
        head.valid = bus.in_valid;
        head.carry = bus.s;
        head.xa    = bus.x;
        head.yb    = bus.y ^ {N{bus.s}};
    end

    generate
        if (STAGES > 1) begin : g_mid
            // Stages 0 .. STAGES-2; the final stage is the output register.
            stage_t stg_q [STAGES-1];

            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples its predecessor's pre-edge value.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < STAGES - 1; k++) begin
                        stg_q[k] <= '0;
                    end
                end else if (adv) begin
                    stg_q[0] <= advance(head);
                    for (int k = 1; k < STAGES - 1; k++) begin
                        stg_q[k] <= advance(stg_q[k-1]);
                    end
                end
            end

            assign last_valid = stg_q[STAGES-2].valid;
            assign last_part  = slice_sum(stg_q[STAGES-2]);
            assign last_low   = stg_q[STAGES-2].sum >> W;
            assign last_xs    = stg_q[STAGES-2].xa[W-1];
            assign last_ys    = stg_q[STAGES-2].yb[W-1];
        end else begin : g_single
            assign last_valid = head.valid;
            assign last_part  = slice_sum(head);
            assign last_low   = head.sum >> W;
            assign last_xs    = head.xa[W-1];
            assign last_ys    = head.yb[W-1];
        end
    endgenerate

    // After the shifts, last_xs/last_ys are bit N-1 of x and of the
    // effective (possibly inverted) y, so this overflow test is right for
    // both add and subtract.
    assign f_raw  = last_low | (N'(last_part[W-1:0]) << (N - W));
    assign ov_raw = (last_xs == last_ys) && (f_raw[N-1] != last_xs);

`ifdef ADD_SUB_SATURATE_EN
    // Positive overflow (x non-negative) clamps to 0111..1, negative
    // overflow to 1000..0.
    always_comb begin
        f_fin = f_raw;
        if (ov_raw) begin
            f_fin = last_xs ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end
`else
    assign f_fin = f_raw;
`endif

    // Output stage: the zero flag is taken from the final (possibly clamped)
    // result and registered so it reads 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            f_q         <= '0;
            cout_q      <= 1'b0;
            ov_q        <= 1'b0;
            zero_q      <= 1'b0;
        end else if (adv) begin
            out_valid_q <= last_valid;
            f_q         <= f_fin;
            cout_q      <= last_part[W];
            ov_q        <= ov_raw;
            zero_q      <= (f_fin == '0);
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.f         = f_q;
    assign bus.cout      = cout_q;
    assign bus.ov        = ov_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// ---------------------------------------------------------------------------
// tb_pipelined_add_sub
//
// Scoreboard bench for pipelined_add_sub at N=8, STAGES=2. Directed vectors
// carry hand-computed results (wrap-around and saturated forms); the driver
// pushes the expected response when an operation is accepted and a separate
// monitor pops and compares whenever a result is handed over.
// ---------------------------------------------------------------------------
module tb_pipelined_add_sub;
    localparam int N      = 8;
    localparam int STAGES = 2;

    typedef struct {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic         s;
        logic [N-1:0] f_wrap;
        logic [N-1:0] f_sat;
        logic         cout;
        logic         ov;
    } vec_t;

    typedef struct {
        logic [N-1:0] f;
        logic         cout;
        logic         ov;
        logic         zero;
        int           acc_cycle;
    } exp_t;

    //                 x      y      s     f_wrap f_sat  cout  ov
    vec_t vecs [16] = '{
        '{8'h7F, 8'h01, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1},
        '{8'h00, 8'h80, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1},
        '{8'h05, 8'h05, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0},
        '{8'h03, 8'h05, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0},
        '{8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0},
        '{8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1},
        '{8'h80, 8'h01, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1},
        '{8'h12, 8'h34, 1'b0, 8'h46, 8'h46, 1'b0, 1'b0},
        '{8'h7F, 8'hFF, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1},
        '{8'hC0, 8'hC0, 1'b0, 8'h80, 8'h80, 1'b1, 1'b0},
        '{8'h10, 8'h20, 1'b1, 8'hF0, 8'hF0, 1'b0, 1'b0},
        '{8'hA5, 8'h5A, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0},
        '{8'h80, 8'h80, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0},
        '{8'h01, 8'hFE, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0},
        '{8'hFF, 8'h7F, 1'b1, 8'h80, 8'h80, 1'b1, 1'b0},
        '{8'h40, 8'h40, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1}
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;
    int   check_count = 0;
    int   pass_count = 0;
    bit   check_latency = 1'b0;
    exp_t sb [$];
    exp_t mon_e;

    pipelined_add_sub_if #(.N(N)) bus ();

    pipelined_add_sub #(.N(N), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        check_count++;
        if (got === want) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, want, cycle);
        end
    endtask

    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
`ifdef ADD_SUB_SATURATE_EN
        e.f = v.f_sat;
`else
        e.f = v.f_wrap;
`endif
        e.cout      = v.cout;
        e.ov        = v.ov;
        e.zero      = (e.f == '0);
        e.acc_cycle = 0;
        return e;
    endfunction

    // Present one operation and hold it until accepted; the expectation is
    // queued at the negedge just before the accepting edge.
    task automatic issue(input vec_t v);
        int   waited;
        exp_t e;
        waited       = 0;
        bus.x        = v.x;
        bus.y        = v.y;
        bus.s        = v.s;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            e           = expect_of(v);
            e.acc_cycle = cycle + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a result is handed over at the next posedge when out_valid
    // and out_ready are both high at the negedge (inputs only change just
    // after a posedge).
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("f",    32'(bus.f),    32'(mon_e.f));
                check("cout", 32'(bus.cout), 32'(mon_e.cout));
                check("ov",   32'(bus.ov),   32'(mon_e.ov));
                check("zero", 32'(bus.zero), 32'(mon_e.zero));
                if (check_latency) begin
                    check("latency", 32'(cycle + 1 - mon_e.acc_cycle),
                          32'(STAGES));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d",
                 cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t head_e;

        bus.x         = '0;
        bus.y         = '0;
        bus.s         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_f",         32'(bus.f),         32'd0);
        check("rst_cout",      32'(bus.cout),      32'd0);
        check("rst_ov",        32'(bus.ov),        32'd0);
        check("rst_zero",      32'(bus.zero),      32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Back-to-back stream, consumer always ready.
        bus.out_ready = 1'b1;
        check_latency = 1'b1;
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i]);
        end
        bus.in_valid = 1'b0;
        wait_drain();
        check_latency = 1'b0;

        // Fill the pipeline with the consumer stalled, then hold 5 cycles
        // while a third operation is offered.
        bus.out_ready = 1'b0;
        issue(vecs[0]);
        issue(vecs[1]);
        bus.in_valid = 1'b0;
        fork
            issue(vecs[2]);
            begin
                head_e = sb[0];
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready",  32'(bus.in_ready),  32'd0);
                    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_f",         32'(bus.f),         32'(head_e.f));
                    check("stall_ov",        32'(bus.ov),        32'(head_e.ov));
                    check("stall_cout",      32'(bus.cout),      32'(head_e.cout));
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        bus.in_valid = 1'b0;
        wait_drain();

        // Reset with two operations in flight.
        issue(vecs[3]);
        issue(vecs[4]);
        bus.in_valid = 1'b0;
        check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_f",         32'(bus.f),         32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Pipeline still works after the mid-operation reset.
        issue(vecs[5]);
        bus.in_valid = 1'b0;
        wait_drain();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
